// File: rtl/dlfloat_dot_seq.sv
// Dot-product sequencer: clears the shared DLFloat16 MAC, issues operand pairs at
// a fixed minimum spacing, waits out the MAC latency and returns the accumulated value.
module dlfloat_dot_seq #(
  parameter int LEN_W     = 8,
  parameter int MAC_LAT   = 4,
  parameter int ISSUE_GAP = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  output logic             mac_vld,
  output logic             mac_clr,
  input  logic [15:0]      mac_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [LEN_W-1:0] out_count,
  output logic             out_nan
);

  localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam int DRN_W = $clog2(MAC_LAT + 1);
  localparam logic [GAP_W-1:0] GAP_RLD = GAP_W'(ISSUE_GAP - 1);
  localparam logic [DRN_W-1:0] DRN_RLD = DRN_W'(MAC_LAT);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ISSUE, S_DRAIN, S_RESULT} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   issued_q, issued_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [DRN_W-1:0]   drn_q, drn_d;
  logic               nan_q, nan_d;
  logic [15:0]        mac_a_q, mac_a_d, mac_b_q, mac_b_d;
  logic               mac_vld_q, mac_vld_d, mac_clr_q, mac_clr_d;
  logic [15:0]        out_data_q, out_data_d;
  logic [LEN_W-1:0]   out_count_q, out_count_d;
  logic               out_nan_q, out_nan_d;
  logic               accept;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issued_d    = issued_q;
    gap_d       = gap_q;
    drn_d       = drn_q;
    nan_d       = nan_q;
    mac_a_d     = '0;
    mac_b_d     = '0;
    mac_vld_d   = 1'b0;
    mac_clr_d   = 1'b0;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_nan_d   = out_nan_q;
    in_ready    = 1'b0;
    accept      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d   = S_CLEAR;
            len_d     = len;
            mac_clr_d = 1'b1;
          end else begin
            state_d     = S_RESULT;
            out_data_d  = '0;
            out_count_d = '0;
            out_nan_d   = 1'b0;
          end
        end
      end
      S_CLEAR: begin
        nan_d    = 1'b0;
        issued_d = '0;
        gap_d    = '0;
        state_d  = S_ISSUE;
      end
      S_ISSUE: begin
        // abort gates ready so an aborted cycle never looks like a handshake upstream
        in_ready = (gap_q == '0) && (issued_q < len_q) && !abort;
        accept   = in_valid && in_ready;
        if (gap_q != '0) gap_d = gap_q - 1'b1;
        if (accept) begin
          mac_a_d   = in_a;
          mac_b_d   = in_b;
          mac_vld_d = 1'b1;
          issued_d  = issued_q + 1'b1;
          gap_d     = GAP_RLD;
          if (in_a == 16'hFFFF || in_b == 16'hFFFF) nan_d = 1'b1;
          if (issued_q == len_q - 1'b1) begin
            state_d = S_DRAIN;
            drn_d   = DRN_RLD;
          end
        end
      end
      S_DRAIN: begin
        if (drn_q == '0) begin
          out_data_d  = mac_result;
          out_count_d = issued_q;
          out_nan_d   = nan_q;
          state_d     = S_RESULT;
        end else begin
          drn_d = drn_q - 1'b1;
        end
      end
      S_RESULT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      mac_clr_d = 1'b1;
      issued_d  = '0;
      gap_d     = '0;
      drn_d     = '0;
      nan_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      gap_q       <= '0;
      drn_q       <= '0;
      nan_q       <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_vld_q   <= 1'b0;
      mac_clr_q   <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_nan_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      gap_q       <= gap_d;
      drn_q       <= drn_d;
      nan_q       <= nan_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_vld_q   <= mac_vld_d;
      mac_clr_q   <= mac_clr_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_nan_q   <= out_nan_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_RESULT);
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_vld   = mac_vld_q;
  assign mac_clr   = mac_clr_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_nan   = out_nan_q;

endmodule

// File: tb/tb_dlfloat_dot_seq.sv
// Bench for dlfloat_dot_seq: behavioural DLFloat16 MAC with fixed latency, directed
// jobs, scoreboard of expected results checked on each result handshake.
module tb_dlfloat_dot_seq;
  localparam int LEN_W = 8, MAC_LAT = 4, ISSUE_GAP = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [15:0] in_a = '0, in_b = '0;
  logic busy, in_ready, mac_vld, mac_clr, out_valid, out_nan;
  logic [15:0] mac_a, mac_b, mac_result, out_data;
  logic [LEN_W-1:0] out_count;

  dlfloat_dot_seq #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT), .ISSUE_GAP(ISSUE_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_vld(mac_vld), .mac_clr(mac_clr),
    .mac_result(mac_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .out_nan(out_nan));

  always #5 clk = ~clk;

  function automatic real dl2r(input logic [15:0] x);
    real v;
    int  e;
    if (x[14:0] == 15'd0) return 0.0;
    e = int'(x[14:9]) - 31;
    v = (1.0 + real'(x[8:0]) / 512.0) * (2.0 ** e);
    return x[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2dl(input real r);
    real  a;
    int   e;
    logic s;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 31;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    return {s, 6'(e), 9'($rtoi((a - 1.0) * 512.0))};
  endfunction

  // MAC model: result of a product visible MAC_LAT cycles after its mac_vld cycle
  real         acc_r = 0.0;
  logic        anan = 1'b0;
  logic [15:0] mp [MAC_LAT];
  assign mac_result = mp[MAC_LAT-1];

  always @(posedge clk) begin : mac_m
    real  nacc;
    logic nnan;
    nacc = acc_r;
    nnan = anan;
    if (mac_clr) begin
      nacc = 0.0;
      nnan = 1'b0;
    end else if (mac_vld) begin
      if (mac_a == 16'hFFFF || mac_b == 16'hFFFF) nnan = 1'b1;
      else nacc = nacc + dl2r(mac_a) * dl2r(mac_b);
    end
    acc_r <= nacc;
    anan  <= nnan;
    mp[0] <= nnan ? 16'hFFFF : r2dl(nacc);
    for (int i = 1; i < MAC_LAT; i++) mp[i] <= mp[i-1];
  end

  typedef struct {
    logic [15:0]      data;
    logic [LEN_W-1:0] cnt;
    logic             nan;
  } exp_t;
  exp_t sb[$];

  int nchk = 0, nerr = 0;
  logic [15:0] opa [8], opb [8];
  int nv, nclr, seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_mac_vld"}, 32'(mac_vld), 32'd0);
    chk({tag, "_mac_clr"}, 32'(mac_clr), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_nan"}, 32'(out_nan), 32'd0);
    chk({tag, "_mac_ab"}, {mac_a, mac_b}, 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_out_count"}, 32'(out_count), 32'd0);
  endtask

  // Runs one job to its result handshake; operands come from opa/opb.
  task automatic run_job(input int n, input bit sparse, input int rdelay, input bit hold_start,
                         input logic [15:0] xd, input int xc, input bit xn);
    int cyc, idx, nvld, nc, out_t, waited;
    bit done, pend;
    logic [15:0] snap;
    int vld_t[$];
    exp_t e;
    sb.push_back('{data: xd, cnt: LEN_W'(xc), nan: xn});
    start = 1'b1;
    len   = LEN_W'(n);
    tick;
    start = hold_start;
    len   = '0;
    cyc = 1; idx = 0; nvld = 0; nc = 0; out_t = -1; waited = 0; done = 0; pend = 0;
    snap = '0;
    while (!done && cyc < 200) begin
      chk("busy_in_job", 32'(busy), 32'd1);
      if (mac_clr) nc++;
      if (mac_vld) begin
        chk("mac_a", 32'(mac_a), 32'(opa[nvld % 8]));
        chk("mac_b", 32'(mac_b), 32'(opb[nvld % 8]));
        vld_t.push_back(cyc);
        nvld++;
      end else begin
        chk("mac_ab_idle", {mac_a, mac_b}, 32'd0);
      end
      if (out_valid) begin
        waited++;
        if (out_t < 0) begin
          out_t = cyc;
          snap  = out_data;
        end else begin
          chk("out_stable", 32'(out_data), 32'(snap));
        end
      end
      if (pend) begin
        idx++;
        pend = 0;
        in_valid = 1'b0;
      end
      if (!in_valid) begin
        in_valid = (idx < n) && (!sparse || (cyc % 3 == 0));
        in_a = opa[idx % 8];
        in_b = opb[idx % 8];
      end
      out_ready = out_valid && (waited > rdelay);
      #1;
      pend = in_valid && in_ready;
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 32'(sb.size()), 32'(1));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_count", 32'(out_count), 32'(e.cnt));
          chk("out_nan", 32'(out_nan), 32'(e.nan));
        end
        done = 1;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("job_done", 32'(done), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
    chk("out_valid_after", 32'(out_valid), 32'd0);
    chk("n_mac_vld", 32'(nvld), 32'(n));
    chk("n_mac_clr", 32'(nc), (n > 0) ? 32'd1 : 32'd0);
    if (!sparse) begin
      chk("out_valid_time", 32'(out_t),
          (n == 0) ? 32'd1 : 32'(3 + ISSUE_GAP * (n - 1) + MAC_LAT + 1));
      for (int i = 0; i < vld_t.size(); i++)
        chk("mac_vld_time", 32'(vld_t[i]), 32'(3 + ISSUE_GAP * i));
    end
  endtask

  initial begin
    repeat (3) tick;
    chk_rst("reset");
    rst_n = 1'b1;
    tick;

    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_idle_busy", 32'(busy), 32'd0);
    chk("abort_idle_clr", 32'(mac_clr), 32'd0);

    // reset in the middle of a 4-pair job
    start = 1'b1; len = 8'd4;
    tick;
    start = 1'b0; len = '0;
    in_valid = 1'b1; in_a = 16'h3E00; in_b = 16'h3E00;
    nv = 0;
    for (int c = 0; c < 20 && nv < 2; c++) begin
      tick;
      if (mac_vld) nv++;
    end
    chk("pre_reset_vld", 32'(nv), 32'd2);
    #2 rst_n = 1'b0;
    #1 chk_rst("midjob_reset");
    in_valid = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;

    opa[0] = 16'h3E00; opb[0] = 16'h4000;
    run_job(1, 0, 0, 0, 16'h4000, 1, 0);

    for (int i = 0; i < 3; i++) begin opa[i] = 16'h3E00; opb[i] = 16'h3E00; end
    run_job(3, 0, 0, 0, 16'h4100, 3, 0);

    run_job(0, 0, 0, 0, 16'h0000, 0, 0);

    opa[0] = 16'h3E00; opa[1] = 16'h4000; opa[2] = 16'h4100; opa[3] = 16'h3F00;
    for (int i = 0; i < 4; i++) opb[i] = 16'h3E00;
    run_job(4, 1, 5, 1, 16'h43C0, 4, 0);

    opa[0] = 16'hFFFF; opb[0] = 16'h3E00; opa[1] = 16'h3E00; opb[1] = 16'h3E00;
    run_job(2, 0, 0, 0, 16'hFFFF, 2, 1);
    opa[0] = 16'h3E00; opb[0] = 16'h4000;
    run_job(1, 0, 0, 0, 16'h4000, 1, 0);

    // abort during DRAIN
    start = 1'b1; len = 8'd2;
    tick;
    start = 1'b0; len = '0;
    in_valid = 1'b1; in_a = 16'h3E00; in_b = 16'h3E00;
    nv = 0;
    for (int c = 0; c < 20 && nv < 2; c++) begin
      tick;
      if (mac_vld) nv++;
    end
    chk("drain_reached", 32'(nv), 32'd2);
    in_valid = 1'b0;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_drain_busy", 32'(busy), 32'd0);
    chk("abort_drain_clr", 32'(mac_clr), 32'd1);
    nclr = 0; seen = 0;
    repeat (8) begin
      tick;
      nclr += int'(mac_clr);
      seen += int'(out_valid);
    end
    chk("abort_drain_extra_clr", 32'(nclr), 32'd0);
    chk("abort_drain_out_valid", 32'(seen), 32'd0);

    // abort in RESULT with a simultaneous handshake
    start = 1'b1; len = 8'd1;
    tick;
    start = 1'b0; len = '0;
    in_valid = 1'b1; in_a = 16'h3E00; in_b = 16'h4000;
    for (int c = 0; c < 30 && !out_valid; c++) tick;
    in_valid = 1'b0;
    chk("result_reached", 32'(out_valid), 32'd1);
    chk("result_data", 32'(out_data), 32'h4000);
    out_ready = 1'b1;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    out_ready = 1'b0;
    chk("abort_res_busy", 32'(busy), 32'd0);
    chk("abort_res_out_valid", 32'(out_valid), 32'd0);
    chk("abort_res_clr", 32'(mac_clr), 32'd1);
    seen = 0;
    repeat (6) begin
      tick;
      seen += int'(out_valid);
    end
    chk("abort_res_no_valid", 32'(seen), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
